// File: rtl/io_pkg.sv
// io_pkg: shared FSM state type, mode encoding and width helpers for the IO stream controller
package io_pkg;
  typedef enum logic [2:0] {
    IDLE,
    HDR_BASE,
    HDR_CNT,
    LD_DATA,
    SD_TURN,
    SD_FETCH,
    SD_DRIVE,
    FINISH
  } state_t;
  localparam logic LOAD = 1'b1;
  localparam logic SEND = 1'b0;
  function automatic int bus_ratio(input int data_width, input int bus_width);
    return data_width / bus_width;
  endfunction
  function automatic int slot_width(input int ratio);
    return ratio > 1 ? $clog2(ratio) : 1;
  endfunction
endpackage

// File: rtl/io_stream_controller_if.sv
// io_stream_controller_if: CPU handshake, status pulses and RAM ports of the IO stream controller
// master = CPU/RAM environment side, slave = the controller itself
interface io_stream_controller_if #(
  parameter int ADDRESS_WIDTH = 13,
  parameter int DATA_WIDTH = 64
);
  logic INT;
  logic Load_Process;
  logic Bus_Valid;
  logic CPU_Ready;
  logic Bus_Out_Valid;
  logic Busy;
  logic Done_Reading_Packet;
  logic Done_Loading;
  logic Done_Sending;
  logic Protocol_Error;
  logic IO_Memory_WR_Enable;
  logic [DATA_WIDTH-1:0] RAM_Data_WR;
  logic [ADDRESS_WIDTH-1:0] RAM_Address_WR;
  logic [ADDRESS_WIDTH-1:0] RAM_Address_RD;
  logic [DATA_WIDTH-1:0] RAM_Data_RD;
  modport master (
    output INT, Load_Process, Bus_Valid, CPU_Ready, RAM_Data_RD,
    input Bus_Out_Valid, Busy, Done_Reading_Packet, Done_Loading, Done_Sending, Protocol_Error,
    input IO_Memory_WR_Enable, RAM_Data_WR, RAM_Address_WR, RAM_Address_RD
  );
  modport slave (
    input INT, Load_Process, Bus_Valid, CPU_Ready, RAM_Data_RD,
    output Bus_Out_Valid, Busy, Done_Reading_Packet, Done_Loading, Done_Sending, Protocol_Error,
    output IO_Memory_WR_Enable, RAM_Data_WR, RAM_Address_WR, RAM_Address_RD
  );
endinterface

// File: rtl/io_word_packer.sv
// io_word_packer: slot counter and shared pack (load) / unpack (send) register
// Ports: clk/rst sync active-high; clear restarts at slot 0; pack stores bus_in into the current slot;
//        unpack loads a whole RAM word; advance steps the slot in send; word_done flags the last slot;
//        packed_next is the register with the current slot replaced by bus_in; slice is the current slot.
module io_word_packer
  import io_pkg::*;
#(
  parameter int BUS_WIDTH = 32,
  parameter int RATIO = 2,
  localparam int SW = slot_width(RATIO)
) (
  input logic clk,
  input logic rst,
  input logic clear,
  input logic pack,
  input logic unpack,
  input logic advance,
  input logic [BUS_WIDTH-1:0] bus_in,
  input logic [BUS_WIDTH*RATIO-1:0] ram_in,
  output logic word_done,
  output logic [BUS_WIDTH*RATIO-1:0] packed_next,
  output logic [BUS_WIDTH-1:0] slice
);
  logic [SW-1:0] slot;
  logic [BUS_WIDTH*RATIO-1:0] buffer;
  assign word_done = slot == SW'(RATIO - 1);
  assign slice = buffer[int'(slot)*BUS_WIDTH +: BUS_WIDTH];
  always_comb begin
    packed_next = buffer;
    packed_next[int'(slot)*BUS_WIDTH +: BUS_WIDTH] = bus_in;
  end
  always_ff @(posedge clk)
    if (rst) begin
      slot <= '0;
      buffer <= '0;
    end else begin
      if (clear) slot <= '0;
      else if (pack || advance) slot <= word_done ? '0 : slot + SW'(1);
      if (pack) buffer <= packed_next;
      else if (unpack) buffer <= ram_in;
    end
endmodule

// File: rtl/io_stream_controller.sv
// io_stream_controller: moves packets between the CPU bus and the solver RAM
// Ports: CLK/RST sync active-high; CPU_Bus shared bus, driven only while presenting send data;
//        io (slave modport) carries INT/Load_Process, Bus_Valid/CPU_Ready handshakes, status
//        pulses (Busy, Done_*, Protocol_Error) and the RAM write/read ports.
module io_stream_controller
  import io_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 13,
  parameter int DATA_WIDTH = 64,
  parameter int BUS_WIDTH = 32
) (
  input logic CLK,
  input logic RST,
  inout wire [BUS_WIDTH-1:0] CPU_Bus,
  io_stream_controller_if.slave io
);
  localparam int RATIO = bus_ratio(DATA_WIDTH, BUS_WIDTH);
  state_t state, state_next;
  logic mode;
  logic [ADDRESS_WIDTH-1:0] base, count, word_idx, rd_addr;
  logic pack_en, advance, fetch, cnt_acc, word_done, word_end, last_word;
  logic [DATA_WIDTH-1:0] packed_next;
  logic [BUS_WIDTH-1:0] slice;
  assign pack_en = state == LD_DATA && io.Bus_Valid;
  assign advance = state == SD_DRIVE && io.CPU_Ready;
  assign fetch = state == SD_FETCH;
  assign cnt_acc = state == HDR_CNT && io.Bus_Valid;
  assign word_end = (pack_en || advance) && word_done;
  assign last_word = word_idx == count - ADDRESS_WIDTH'(1);
  assign io.Busy = state != IDLE;
  assign io.Bus_Out_Valid = state == SD_DRIVE;
  assign io.RAM_Address_RD = rd_addr;
  assign CPU_Bus = state == SD_DRIVE ? slice : 'z;
  io_word_packer #(
    .BUS_WIDTH(BUS_WIDTH),
    .RATIO(RATIO)
  ) packer (
    .clk(CLK),
    .rst(RST),
    .clear(cnt_acc),
    .pack(pack_en),
    .unpack(fetch),
    .advance(advance),
    .bus_in(CPU_Bus),
    .ram_in(io.RAM_Data_RD),
    .word_done(word_done),
    .packed_next(packed_next),
    .slice(slice)
  );
  always_ff @(posedge CLK) state <= RST ? IDLE : state_next;
  always_comb begin
    state_next = state;
    case (state)
      IDLE: state_next = io.INT ? HDR_BASE : IDLE;
      HDR_BASE: state_next = io.Bus_Valid ? HDR_CNT : HDR_BASE;
      HDR_CNT:
        if (io.Bus_Valid)
          state_next = CPU_Bus[ADDRESS_WIDTH-1:0] == '0 ? FINISH : mode == LOAD ? LD_DATA : SD_TURN;
      LD_DATA: state_next = word_end && last_word ? FINISH : LD_DATA;
      SD_TURN: state_next = SD_FETCH;
      SD_FETCH: state_next = SD_DRIVE;
      SD_DRIVE: state_next = word_end ? (last_word ? FINISH : SD_FETCH) : SD_DRIVE;
      default: state_next = IDLE;
    endcase
  end
  // rd_addr runs one word ahead of the drive phase so the 1-cycle RAM latency is hidden:
  // it is presented during SD_TURN / SD_DRIVE and the data is ready by the end of SD_FETCH.
  always_ff @(posedge CLK)
    if (RST) begin
      mode <= SEND;
      base <= '0;
      count <= '0;
      word_idx <= '0;
      rd_addr <= '0;
      io.IO_Memory_WR_Enable <= 1'b0;
      io.Done_Reading_Packet <= 1'b0;
      io.RAM_Data_WR <= '0;
      io.RAM_Address_WR <= '0;
      io.Done_Loading <= 1'b0;
      io.Done_Sending <= 1'b0;
      io.Protocol_Error <= 1'b0;
    end else begin
      if (state == IDLE && io.INT) mode <= io.Load_Process;
      if (state == HDR_BASE && io.Bus_Valid) base <= CPU_Bus[ADDRESS_WIDTH-1:0];
      if (cnt_acc) begin
        count <= CPU_Bus[ADDRESS_WIDTH-1:0];
        word_idx <= '0;
        rd_addr <= base;
      end else begin
        if (word_end) word_idx <= word_idx + ADDRESS_WIDTH'(1);
        if (fetch) rd_addr <= rd_addr + ADDRESS_WIDTH'(1);
      end
      io.IO_Memory_WR_Enable <= pack_en && word_done;
      io.Done_Reading_Packet <= pack_en && word_done;
      if (pack_en && word_done) begin
        io.RAM_Data_WR <= packed_next;
        io.RAM_Address_WR <= base + word_idx;
      end
      io.Done_Loading <= state == FINISH && mode == LOAD;
      io.Done_Sending <= state == FINISH && mode == SEND;
      io.Protocol_Error <= io.INT && state != IDLE;
    end
endmodule

// File: doc/io_stream_controller.md
Name: io_stream_controller

Overview:
- Parametrised successor of the CPU-bus IO front end.
- Moves packets between the 32-bit CPU bus and the solver RAM in one block. Mode is latched by a clean FSM; there are no combinational enable latches.
- Load mode: packs BUS_WIDTH bus words into DATA_WIDTH RAM words and writes them from a header-supplied base address.
- Send mode: reads RAM and unpacks onto the bus with valid/ready backpressure and a bus turnaround cycle.

Parameters:
- ADDRESS_WIDTH, 13, RAM address width; also the width of the word count.
- DATA_WIDTH, 64, RAM word width. Must be an integer multiple of BUS_WIDTH.
- BUS_WIDTH, 32, CPU bus width. Must be >= ADDRESS_WIDTH.
- RATIO (localparam), DATA_WIDTH/BUS_WIDTH, number of bus words per RAM word.

Ports:
- CLK  in  1  clock, rising edge.
- RST  in  1  synchronous, active-high reset.
- INT  in  1  CPU request pulse; sampled only in IDLE.
- Load_Process  in  1  sampled with INT: 1 = load, 0 = send.
- CPU_Bus  inout  BUS_WIDTH  shared bus; driven only in SD_DRIVE, high-Z otherwise.
- Bus_Valid  in  1  CPU has a valid word on CPU_Bus (headers and load data).
- CPU_Ready  in  1  CPU accepts the driven word this cycle (send).
- Bus_Out_Valid  out  1  block drives a valid word on CPU_Bus.
- Busy  out  1  FSM not in IDLE.
- Done_Reading_Packet  out  1  1-cycle pulse per RAM word written.
- Done_Loading  out  1  1-cycle pulse at load completion.
- Done_Sending  out  1  1-cycle pulse at send completion.
- Protocol_Error  out  1  1-cycle pulse when INT arrives while Busy.
- IO_Memory_WR_Enable  out  1  RAM write strobe.
- RAM_Data_WR  out  DATA_WIDTH  RAM write data.
- RAM_Address_WR  out  ADDRESS_WIDTH  RAM write address.
- RAM_Address_RD  out  ADDRESS_WIDTH  RAM read address; the RAM has 1-cycle synchronous read latency.
- RAM_Data_RD  in  DATA_WIDTH  RAM read data.

Behaviour:
- Reset (applies mid-operation too): FSM goes to IDLE. All outputs, counters, the pack register and the address registers are 0. Bus is high-Z. A pending write strobe is dropped.
- States: IDLE, HDR_BASE, HDR_CNT, LD_DATA, SD_TURN, SD_FETCH, SD_DRIVE, FINISH.
- IDLE:
  - INT=1 latches mode = Load_Process and moves to HDR_BASE.
  - INT=0 stays in IDLE.
- HDR_BASE: on Bus_Valid, base = CPU_Bus[ADDRESS_WIDTH-1:0]; go to HDR_CNT.
- HDR_CNT: on Bus_Valid, count = CPU_Bus[ADDRESS_WIDTH-1:0].
  - count == 0: go to FINISH.
  - load mode: go to LD_DATA.
  - send mode: go to SD_TURN.
- LD_DATA: each Bus_Valid cycle packs the bus word into slice slot_idx, where slot 0 is bits [BUS_WIDTH-1:0] (little-endian).
  - When slot_idx == RATIO-1, the next cycle asserts IO_Memory_WR_Enable for exactly 1 cycle, with RAM_Address_WR = base + word_idx (modulo 2^ADDRESS_WIDTH) and RAM_Data_WR = the packed word. Done_Reading_Packet pulses in the same cycle.
  - Accepting the next word in that cycle is legal, so full throughput is one bus word per cycle.
  - After the last word's write is issued, go to FINISH.
  - Bus_Valid low stalls with no state change.
- SD_TURN: one idle cycle; the bus stays high-Z. Then go to SD_FETCH.
- SD_FETCH: RAM_Address_RD = base + word_idx. Next cycle, capture RAM_Data_RD into the unpack register and go to SD_DRIVE.
- SD_DRIVE:
  - Drive slice slot_idx with Bus_Out_Valid = 1.
  - Advance the slot on CPU_Ready.
  - After slice RATIO-1 is accepted: if words remain, return to SD_FETCH; otherwise go to FINISH.
  - CPU_Ready low holds the data and valid stable.
- FINISH: pulse Done_Loading or Done_Sending (according to mode) for 1 cycle, then go to IDLE.
- INT while Busy: ignored; Protocol_Error pulses 1 cycle; the current transfer is unaffected.
- INT in the same cycle as FINISH: ignored, with Protocol_Error.
- Address wrap: base + word_idx wraps at 2^ADDRESS_WIDTH with no error.

Decomposition:
- Package io_pkg:
  - state enum;
  - RATIO and slot-index width computation (clog2, minimum 1);
  - mode constants LOAD=1, SEND=0.
- One natural sub-module: io_word_packer.
  - Handles the shift/pack in load and the slice select in send.
  - Provides slot counter and word-complete flag.
  - Parametrised by BUS_WIDTH and RATIO.

Test Plan:
- Load, base=0x010, count=2, bus words 0x11111111, 0x22222222, 0x33333333, 0x44444444 back-to-back -> 2 writes:
  - @0x010 = 0x2222222211111111;
  - @0x011 = 0x4444444433333333;
  - 2 Done_Reading_Packet pulses, then 1 Done_Loading.
- Send, base=0x010, count=2 after the above -> bus drives 0x11111111, 0x22222222, 0x33333333, 0x44444444 in order after the turnaround cycle, then Done_Sending. Toggling CPU_Ready 1/0 holds data stable.
- count=0 in either mode -> no RAM access, Done pulse 2 cycles after the count header.
- Load with base=0x1FFF, count=2 -> writes to 0x1FFF then 0x0000.
- INT during LD_DATA -> Protocol_Error pulse, transfer completes unchanged. RST asserted mid-send -> next cycle IDLE, bus high-Z, no Done pulse.
- Load with Bus_Valid gaps (1,0,0,1,...) -> identical RAM contents to the back-to-back case.
